// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    // Who owns the port (or the read data returning next cycle).
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_EXT
    } owner_t;

    // Byte-enable width for the 32-bit data path (DATA_W/8).
    localparam int BE_W = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core memory stage, the external master and the memory.
// Handshake: the core request is qualified as (|core_en)&(core_wea|core_rea) and
// is held stable while mem_hold=1; ext_req is held until ext_gnt pulses for one
// cycle; read data returns one cycle after the grant (ext_rvalid / core_dout).
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) ();
    // core side
    logic [BE_W-1:0]   core_en;
    logic              core_wea;
    logic              core_rea;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_din;
    logic [DATA_W-1:0] core_dout;
    logic              mem_hold;
    // external master side
    logic              ext_req;
    logic              ext_we;
    logic [BE_W-1:0]   ext_be;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_lock;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;
    // memory side
    logic [BE_W-1:0]   mem_en;
    logic              mem_wea;
    logic              mem_rea;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    // status and debug visibility of internal state
    logic [CNT_W-1:0]  stall_cnt;
    owner_t            dbg_last_grant;
    owner_t            dbg_rd_owner;

    // Arbiter view.
    modport slave (
        input  core_en, core_wea, core_rea, core_addr, core_din,
        output core_dout, mem_hold,
        input  ext_req, ext_we, ext_be, ext_addr, ext_wdata, ext_lock,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_en, mem_wea, mem_rea, mem_addr, mem_din,
        input  mem_dout,
        output stall_cnt, dbg_last_grant, dbg_rd_owner
    );

    // Environment view (masters plus memory).
    modport master (
        output core_en, core_wea, core_rea, core_addr, core_din,
        input  core_dout, mem_hold,
        output ext_req, ext_we, ext_be, ext_addr, ext_wdata, ext_lock,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_en, mem_wea, mem_rea, mem_addr, mem_din,
        output mem_dout,
        input  stall_cnt, dbg_last_grant, dbg_rd_owner
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with external lock override.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   Rst,
    input  logic   i_core_req,
    input  logic   i_ext_req,
    input  logic   i_lock,
    output logic   o_gnt_core,
    output logic   o_gnt_ext,
    output owner_t o_last_grant
);
    owner_t r_last_grant;
    owner_t w_last_nxt;

    // last_grant register; reset to EXT so the core wins the first contention.
    always_ff @(posedge clk) begin
        if (Rst) r_last_grant <= OWN_EXT;
        else     r_last_grant <= w_last_nxt;
    end

    // Grant decision and last_grant update; contention is both requesting.
    always_comb begin
        o_gnt_core = 1'b0;
        o_gnt_ext  = 1'b0;
        w_last_nxt = r_last_grant;
        if (!Rst) begin
            if (i_lock) begin
                o_gnt_ext = i_ext_req;
            end else if (i_core_req && i_ext_req) begin
                o_gnt_core = (r_last_grant == OWN_EXT);
                o_gnt_ext  = (r_last_grant != OWN_EXT);
            end else begin
                o_gnt_core = i_core_req;
                o_gnt_ext  = i_ext_req;
            end
            // A locked contention counts as an EXT win, so the core goes next.
            if (i_core_req && i_ext_req)
                w_last_nxt = o_gnt_ext ? OWN_EXT : OWN_CORE;
        end
    end

    assign o_last_grant = r_last_grant;
endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port sharing between the core memory stage and an external master.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        Rst,
    dmem_arbiter_if.slave bus
);
    logic              w_core_req;
    logic              w_gnt_core;
    logic              w_gnt_ext;
    logic              w_hold;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;
    owner_t            r_rd_owner;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_core_req = (|bus.core_en) & (bus.core_wea | bus.core_rea);

    rr_arb2 u_rr_arb2 (
        .clk          (clk),
        .Rst          (Rst),
        .i_core_req   (w_core_req),
        .i_ext_req    (bus.ext_req),
        .i_lock       (bus.ext_lock),
        .o_gnt_core   (w_gnt_core),
        .o_gnt_ext    (w_gnt_ext),
        .o_last_grant (bus.dbg_last_grant)
    );

    // The core is held whenever it requests but does not own the port.
    assign w_hold = w_core_req & ~w_gnt_core & ~Rst;

    // Memory port mux: idle (all strobes low) unless someone is granted.
    always_comb begin
        bus.mem_en  = '0;
        bus.mem_wea = 1'b0;
        bus.mem_rea = 1'b0;
        w_addr      = '0;
        w_din       = '0;
        if (w_gnt_core) begin
            bus.mem_en  = bus.core_en;
            bus.mem_wea = bus.core_wea;
            bus.mem_rea = bus.core_rea;
            w_addr      = bus.core_addr;
            w_din       = bus.core_din;
        end else if (w_gnt_ext) begin
            bus.mem_en  = bus.ext_be;
            bus.mem_wea = bus.ext_we;
            bus.mem_rea = ~bus.ext_we;
            w_addr      = bus.ext_addr;
            w_din       = bus.ext_wdata;
        end
    end

    // Remember who issued a read so the returning data is steered next cycle.
    always_ff @(posedge clk) begin
        if (Rst)                              r_rd_owner <= OWN_NONE;
        else if (w_gnt_core && bus.core_rea)  r_rd_owner <= OWN_CORE;
        else if (w_gnt_ext && !bus.ext_we)    r_rd_owner <= OWN_EXT;
        else                                  r_rd_owner <= OWN_NONE;
    end

    // Saturating count of held cycles.
    always_ff @(posedge clk) begin
        if (Rst)                       r_stall_cnt <= '0;
        else if (w_hold && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign bus.mem_addr     = w_addr;
    assign bus.mem_din      = w_din;
    assign bus.mem_hold     = w_hold;
    assign bus.ext_gnt      = w_gnt_ext;
    // Gated by Rst so a read in flight when reset hits is dropped.
    assign bus.ext_rvalid   = (r_rd_owner == OWN_EXT) & ~Rst;
    assign bus.ext_rdata    = bus.mem_dout;
    assign bus.core_dout    = bus.mem_dout;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.dbg_rd_owner = r_rd_owner;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a small synchronous memory model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk;
    logic Rst;
    int   n_checks;
    int   n_fail;

    logic [31:0] ext_q[$];
    logic [31:0] core_q[$];
    logic        core_pend;
    logic [31:0] tb_mem [0:255];

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // synchronous memory, 1-cycle read latency, byte-enabled writes
    always @(posedge clk) begin
        if (bus.mem_wea) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_en[b]) tb_mem[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_din[b*8 +: 8];
        end
        if (bus.mem_rea) bus.mem_dout <= tb_mem[bus.mem_addr[9:2]];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // read-return scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (core_pend) begin
            if (core_q.size() == 0) check_eq("core_rd_unexpected", 64'(core_q.size()), 64'd1);
            else                    check_eq("core_dout", bus.core_dout, core_q.pop_front());
        end
        core_pend = bus.mem_rea && !bus.ext_gnt;
        if (bus.ext_rvalid) begin
            if (ext_q.size() == 0) check_eq("ext_rvalid_unexpected", bus.ext_rvalid, 1'b0);
            else                   check_eq("ext_rdata", bus.ext_rdata, ext_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.core_en = '0; bus.core_wea = 0; bus.core_rea = 0; bus.core_addr = '0; bus.core_din = '0;
        bus.ext_req = 0; bus.ext_we = 0; bus.ext_be = '0; bus.ext_addr = '0; bus.ext_wdata = '0;
        bus.ext_lock = 0;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        Rst = 1'b0;
    endtask

    task automatic drive_core(input logic we, input logic [31:0] addr, input logic [31:0] din);
        bus.core_en = 4'hF; bus.core_wea = we; bus.core_rea = ~we;
        bus.core_addr = addr; bus.core_din = din;
    endtask

    task automatic drive_ext(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.ext_req = 1; bus.ext_we = we; bus.ext_be = 4'hF;
        bus.ext_addr = addr; bus.ext_wdata = wdata;
    endtask

    initial begin
        logic exp_ext;
        n_checks = 0;
        n_fail = 0;
        core_pend = 0;
        bus.mem_dout = '0;
        for (int i = 0; i < 256; i++) tb_mem[i] = $urandom_range(32'hFFFF, 0) ^ (i << 16);
        tb_mem[32'h100 >> 2] = 32'hDEADBEEF;
        tb_mem[32'h80 >> 2]  = 32'h11112222;
        tb_mem[32'h84 >> 2]  = 32'h33334444;

        // reset state
        Rst = 1'b1;
        clear_inputs();
        drive_core(1'b0, 32'h10, 32'h0);
        drive_ext(1'b0, 32'h20, 32'h0);
        tick();
        check_eq("rst_mem_en", bus.mem_en, 4'h0);
        check_eq("rst_ext_gnt", bus.ext_gnt, 1'b0);
        check_eq("rst_mem_hold", bus.mem_hold, 1'b0);
        check_eq("rst_stall_cnt", bus.stall_cnt, 16'd0);
        check_eq("rst_ext_rvalid", bus.ext_rvalid, 1'b0);
        do_reset();

        // core-only read
        drive_core(1'b0, 32'h100, 32'h0);
        core_q.push_back(32'hDEADBEEF);
        #1;
        check_eq("core_rd_mem_rea", bus.mem_rea, 1'b1);
        check_eq("core_rd_mem_addr", bus.mem_addr, 32'h100);
        check_eq("core_rd_hold", bus.mem_hold, 1'b0);
        tick();
        clear_inputs();
        tick();
        check_eq("core_rd_stall_cnt", bus.stall_cnt, 16'd0);

        // ext-only write
        drive_ext(1'b1, 32'h40, 32'hCAFEF00D);
        #1;
        check_eq("ext_wr_gnt", bus.ext_gnt, 1'b1);
        check_eq("ext_wr_mem_wea", bus.mem_wea, 1'b1);
        check_eq("ext_wr_mem_rea", bus.mem_rea, 1'b0);
        check_eq("ext_wr_mem_din", bus.mem_din, 32'hCAFEF00D);
        check_eq("ext_wr_mem_addr", bus.mem_addr, 32'h40);
        check_eq("ext_wr_mem_en", bus.mem_en, 4'hF);
        tick();
        clear_inputs();
        #1;
        check_eq("ext_wr_gnt_pulse", bus.ext_gnt, 1'b0);
        tick();
        check_eq("ext_wr_rvalid", bus.ext_rvalid, 1'b0);
        check_eq("ext_wr_tb_mem", tb_mem[32'h40 >> 2], 32'hCAFEF00D);

        // contention without lock: strict alternation starting with the core
        do_reset();
        drive_core(1'b1, 32'h200, 32'h0);
        drive_ext(1'b1, 32'h300, 32'h0);
        for (int i = 0; i < 6; i++) begin
            bus.core_din  = $urandom_range(32'hFFFF, 0);
            bus.ext_wdata = $urandom_range(32'hFFFF, 0);
            exp_ext = (i % 2 == 1);
            #1;
            check_eq($sformatf("alt_gnt_%0d", i), bus.ext_gnt, exp_ext);
            check_eq($sformatf("alt_hold_%0d", i), bus.mem_hold, exp_ext);
            check_eq($sformatf("alt_addr_%0d", i), bus.mem_addr, exp_ext ? 32'h300 : 32'h200);
            tick();
        end
        clear_inputs();
        #1;
        check_eq("alt_stall_cnt", bus.stall_cnt, 16'd3);

        // lock: ext owns the port, core held every cycle
        do_reset();
        drive_core(1'b1, 32'h210, 32'h0);
        drive_ext(1'b1, 32'h310, 32'h0);
        bus.ext_lock = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq($sformatf("lock_gnt_%0d", i), bus.ext_gnt, 1'b1);
            check_eq($sformatf("lock_hold_%0d", i), bus.mem_hold, 1'b1);
            tick();
        end
        bus.ext_lock = 0;
        #1;
        check_eq("unlock_core_gnt", bus.ext_gnt, 1'b0);
        check_eq("unlock_hold", bus.mem_hold, 1'b0);
        check_eq("unlock_addr", bus.mem_addr, 32'h210);
        tick();
        clear_inputs();
        #1;
        check_eq("lock_stall_cnt", bus.stall_cnt, 16'd10);
        // lock with no ext request: port idle, core still held
        drive_core(1'b1, 32'h220, 32'h0);
        bus.ext_lock = 1;
        #1;
        check_eq("lock_idle_hold", bus.mem_hold, 1'b1);
        check_eq("lock_idle_mem_en", bus.mem_en, 4'h0);
        check_eq("lock_idle_wea", bus.mem_wea, 1'b0);
        tick();
        clear_inputs();
        #1;
        check_eq("lock_idle_stall_cnt", bus.stall_cnt, 16'd11);

        // ext read then core read back-to-back
        do_reset();
        drive_ext(1'b0, 32'h80, 32'h0);
        ext_q.push_back(32'h11112222);
        #1;
        check_eq("b2b_ext_gnt", bus.ext_gnt, 1'b1);
        check_eq("b2b_ext_rea", bus.mem_rea, 1'b1);
        tick();
        clear_inputs();
        drive_core(1'b0, 32'h84, 32'h0);
        core_q.push_back(32'h33334444);
        #1;
        check_eq("b2b_ext_rvalid", bus.ext_rvalid, 1'b1);
        check_eq("b2b_core_rea", bus.mem_rea, 1'b1);
        check_eq("b2b_core_addr", bus.mem_addr, 32'h84);
        check_eq("b2b_core_no_ext_gnt", bus.ext_gnt, 1'b0);
        tick();
        clear_inputs();
        #1;
        check_eq("b2b_rvalid_drop", bus.ext_rvalid, 1'b0);
        tick();

        // reset right after an ext read grant
        do_reset();
        drive_ext(1'b0, 32'h80, 32'h0);
        #1;
        check_eq("rst_mid_gnt", bus.ext_gnt, 1'b1);
        tick();
        Rst = 1'b1;
        drive_core(1'b1, 32'h230, 32'h0);
        #1;
        check_eq("rst_mid_rvalid", bus.ext_rvalid, 1'b0);
        check_eq("rst_mid_no_gnt", bus.ext_gnt, 1'b0);
        check_eq("rst_mid_mem_en", bus.mem_en, 4'h0);
        check_eq("rst_mid_hold", bus.mem_hold, 1'b0);
        tick();
        Rst = 1'b0;
        drive_ext(1'b1, 32'h330, 32'h0);
        #1;
        check_eq("rst_mid_stall_cnt", bus.stall_cnt, 16'd0);
        check_eq("rst_mid_core_first", bus.ext_gnt, 1'b0);
        check_eq("rst_mid_core_addr", bus.mem_addr, 32'h230);
        tick();
        clear_inputs();
        tick();
        tick();

        check_eq("ext_q_left", 64'(ext_q.size()), 64'd0);
        check_eq("core_q_left", 64'(core_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two masters: the core memory stage and an external master (UART programmer or debug loader).
- Performs per-cycle round-robin arbitration on contention.
- Stalls the core pipeline through mem_hold whenever the core loses the port.
- Supports a lock mode that gives the external master exclusive ownership for programming bursts.

Parameters:
- ADDR_W, 32, address width for both masters and the memory.
- DATA_W, 32, data width. Byte enables are DATA_W/8 bits.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock
- Rst  in  1  reset
- core_en  in  4  core byte enables
- core_wea  in  1  core write strobe
- core_rea  in  1  core read strobe
- core_addr  in  ADDR_W  core address
- core_din  in  DATA_W  core write data
- core_dout  out  DATA_W  core read data, valid the cycle after a core read grant
- mem_hold  out  1  stall request to the core pipeline
- ext_req  in  1  external request, held until granted
- ext_we  in  1  external write (0 = read)
- ext_be  in  4  external byte enables
- ext_addr  in  ADDR_W  external address
- ext_wdata  in  DATA_W  external write data
- ext_lock  in  1  external exclusive ownership (tied to programmer enable)
- ext_gnt  out  1  external grant, 1-cycle pulse per accepted access
- ext_rvalid  out  1  external read data valid
- ext_rdata  out  DATA_W  external read data
- mem_en  out  4  memory byte enables
- mem_wea  out  1  memory write
- mem_rea  out  1  memory read
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data (synchronous memory, 1-cycle latency)
- stall_cnt  out  CNT_W  count of cycles in which the core was held

Behaviour:
- Reset is synchronous and active-high on Rst; clock is clk.
- Reset values: last_grant=EXT (core wins the first contention), rd_owner=NONE, ext_rvalid=0, stall_cnt=0. All mem_* outputs, ext_gnt and mem_hold are 0 while Rst is high.
- Request qualification:
  - core_req = (|core_en) & (core_wea | core_rea).
  - ext_req is taken as-is.
- Grant is combinational, decided every cycle:
  - ext_lock=1: EXT is granted whenever ext_req=1. If core_req=1, mem_hold=1. If ext_lock=1 and ext_req=0, the port stays idle and mem_hold=core_req.
  - Only one requester: that requester is granted.
  - Both request, no lock: the requester opposite last_grant wins, i.e. the two alternate strictly.
  - last_grant updates on every contested grant only.
- Core grant:
  - mem_* is driven from core_*, mem_hold=0.
  - A core grant with core_rea=1 sets rd_owner=CORE for the next cycle.
- EXT grant:
  - mem_* is driven from ext_*; mem_en=ext_be; mem_wea=ext_we; mem_rea=~ext_we.
  - ext_gnt=1.
  - mem_hold=core_req.
  - An EXT read sets rd_owner=EXT.
- Core stalls: the core holds its request stable while mem_hold=1, and the arbiter re-arbitrates the next cycle. Maximum core stall without lock is 1 cycle.
- Read return, one cycle after the grant:
  - rd_owner=EXT: ext_rvalid=1, ext_rdata=mem_dout.
  - core_dout=mem_dout always. Its value is meaningful only when rd_owner=CORE.
- Back-to-back accesses need no idle cycle. Every cycle may carry a new grant while the previous read's data returns.
- stall_cnt increments each cycle mem_hold=1 and saturates at all-ones. It does not wrap.
- No grant in a cycle: mem_en=0, mem_wea=0, mem_rea=0.
- Reset mid-operation: a pending rvalid is dropped and no grant is issued during reset. The external master must re-issue its request.
- Asserting ext_lock mid-contention takes effect in the same cycle.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - typedef enum owner_t {OWN_NONE, OWN_CORE, OWN_EXT};
  - a constant for the byte-enable width.
- Sub-module rr_arb2 (2-way round-robin with lock override and last_grant flop) is natural.
- The datapath muxing, read-return tracking and stall counter stay in the top module.

Test Plan:
- Core-only read at 0x100 with mem returning 0xDEADBEEF -> mem_rea=1 at cycle N; core_dout=0xDEADBEEF at N+1; mem_hold never asserted; stall_cnt=0.
- EXT-only write 0xCAFEF00D to 0x40 with be=4'hF -> ext_gnt pulses one cycle; mem_wea=1; mem_din=0xCAFEF00D; ext_rvalid stays 0.
- Both request continuously for 6 cycles, no lock, first contention after reset -> grants alternate CORE, EXT, CORE, EXT, …; mem_hold=1 on the EXT cycles; stall_cnt=3.
- ext_lock=1 with ext_req and core_req both high for 10 cycles -> 10 EXT grants; mem_hold=1 throughout; stall_cnt=10; the core is granted the cycle after lock drops.
- EXT read of 0x80 followed immediately by a core read of 0x84 -> ext_rvalid=1 with the 0x80 data in the same cycle the core grant is issued; core_dout carries the 0x84 data one cycle later.
- Rst asserted the cycle after an EXT read grant -> ext_rvalid stays 0, stall_cnt=0, and the first contention after reset is granted to CORE.
